// File: rtl/div_pkg.sv
// Shared definitions for the divider arbiter and the SDivider datapath it feeds.
package div_pkg;

    localparam int unsigned BW_DSOR_DEF = 4;
    localparam int unsigned BW_DEND_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_RUN       = 3'd3,
        S_DONE      = 3'd4,
        S_ABORT     = 3'd5
    } state_t;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after (ptr+1) mod N.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned bw_id = 2
) (
    input  logic [N-1:0]     req,
    input  logic [bw_id-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [bw_id-1:0] idx,
    output logic             any
);

    int unsigned    k;
    logic [N-1:0]   rot;

    // Walk the candidates from farthest to nearest so the nearest one wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        rot = '0;
        for (int unsigned i = N; i >= 1; i--) begin
            k   = (32'(ptr) + i) % N;
            rot = req >> k;
            if (rot[0]) begin
                idx = bw_id'(k);
                gnt = N'(1) << k;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one SDivider between N_REQ requesters, with a hung-divider watchdog.
module div_arbiter
    import div_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned bw_id   = 2,
    parameter int unsigned bw_Dsor = BW_DSOR_DEF,
    parameter int unsigned bw_Dend = BW_DEND_DEF,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    input  logic [N_REQ-1:0]           Req,
    input  logic [N_REQ*bw_Dsor-1:0]   ReqDsor,
    input  logic [N_REQ*bw_Dend-1:0]   ReqDend,
    output logic [N_REQ-1:0]           Gnt,
    output logic                       Done,
    output logic [bw_id-1:0]           DoneId,
    output logic [bw_Dend-1:0]         Quo,
    output logic                       Err,
    output logic                       DivStart,
    output logic [bw_Dsor-1:0]         DivDsor,
    output logic [bw_Dend-1:0]         DivDend,
    input  logic                       DivBusy,
    input  logic [bw_Dend-1:0]         DivQuo
);

    localparam int unsigned BW_CNT = $clog2(TIMEOUT + 1);

    state_t              state;
    logic [bw_id-1:0]    ptr;
    logic [bw_id-1:0]    id;
    logic                wait_cnt;
    logic [BW_CNT-1:0]   run_cnt;

    logic [N_REQ-1:0]    pick_gnt;
    logic [bw_id-1:0]    pick_idx;
    logic                pick_any;
    logic [bw_Dsor-1:0]  sel_dsor;
    logic [bw_Dend-1:0]  sel_dend;

    rr_pick #(.N(N_REQ), .bw_id(bw_id)) u_pick (
        .req (Req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign sel_dsor = bw_Dsor'(ReqDsor >> (32'(pick_idx) * bw_Dsor));
    assign sel_dend = bw_Dend'(ReqDend >> (32'(pick_idx) * bw_Dend));

    // Result outputs are loaded on the transition into DONE/ABORT, so Done shows in that state.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            ptr      <= bw_id'(N_REQ - 1);
            id       <= '0;
            wait_cnt <= 1'b0;
            run_cnt  <= '0;
            Gnt      <= '0;
            Done     <= 1'b0;
            DoneId   <= '0;
            Quo      <= '0;
            Err      <= 1'b0;
            DivStart <= 1'b0;
            DivDsor  <= '0;
            DivDend  <= '0;
        end else begin
            Gnt      <= '0;
            Done     <= 1'b0;
            Err      <= 1'b0;
            DivStart <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        Gnt     <= pick_gnt;
                        DivDsor <= sel_dsor;
                        DivDend <= sel_dend;
                        id      <= pick_idx;
                        ptr     <= pick_idx;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    // Hold off the start pulse while a previous job still reports Busy.
                    if (!DivBusy) begin
                        DivStart <= 1'b1;
                        wait_cnt <= 1'b0;
                        state    <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (DivBusy) begin
                        run_cnt <= '0;
                        state   <= S_RUN;
                    end else if (wait_cnt) begin
                        Quo    <= '0;
                        Err    <= 1'b1;
                        Done   <= 1'b1;
                        DoneId <= id;
                        state  <= S_ABORT;
                    end else begin
                        wait_cnt <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!DivBusy) begin
                        Quo    <= DivQuo;
                        Done   <= 1'b1;
                        DoneId <= id;
                        state  <= S_DONE;
                    end else if (run_cnt == BW_CNT'(TIMEOUT - 1)) begin
                        Quo    <= '0;
                        Err    <= 1'b1;
                        Done   <= 1'b1;
                        DoneId <= id;
                        state  <= S_ABORT;
                    end else begin
                        run_cnt <= run_cnt + BW_CNT'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ABORT: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
